// File: rtl/ptmch_pkg.sv
// rtl/ptmch_pkg.sv - shared types and constants for the ptmch SPI link
// Purpose: FSM state encoding for the SPI transmitter, the link word width
// shared with the receiver, and a helper used to size the phase timer.
package ptmch_pkg;

  localparam int PTMCH_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_tx_state_t;

  // Largest of four timing parameters; one down-counter serves every phase.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ptmch_spi_tx_if.sv
// rtl/ptmch_spi_tx_if.sv - host push port and SPI pins of the ptmch SPI transmitter
// Purpose: bundles the command push handshake, status and the 3-wire SPI link.
// Signals:
//   tx_data/tx_valid/tx_ready  command word push (accepted on valid & ready)
//   busy, done_pls             status: frame or queued word pending, end-of-frame pulse
//   spi_cs/spi_clk/spi_mosi    active-low select, mode-0 clock, MSB-first data
// Modports: master = transmitter side, slave = host/pin side.
interface ptmch_spi_tx_if
  import ptmch_pkg::*;
#(
  parameter int DATA_W = PTMCH_DATA_W
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done_pls;
  logic              spi_cs;
  logic              spi_clk;
  logic              spi_mosi;

  modport master (
    input  tx_data, tx_valid,
    output tx_ready, busy, done_pls, spi_cs, spi_clk, spi_mosi
  );

  modport slave (
    output tx_data, tx_valid,
    input  tx_ready, busy, done_pls, spi_cs, spi_clk, spi_mosi
  );
endinterface

// File: rtl/ptmch_tx_fifo.sv
// rtl/ptmch_tx_fifo.sv - command word queue for the ptmch SPI transmitter
// Purpose: synchronous FIFO, DATA_W x DEPTH, DEPTH a power of two.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (flushes the queue)
//   push, push_data  write request and word
//   pop, pop_data    read request and head-of-queue word (valid when !empty)
//   full, empty      queue level flags
//   count            number of words held
module ptmch_tx_fifo
  import ptmch_pkg::*;
#(
  parameter int DATA_W = PTMCH_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en, rd_en;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full queue only lands when the head leaves on the same edge.
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/ptmch_spi_tx.sv
// rtl/ptmch_spi_tx.sv - SPI master transmitter for the ptmch command link
// Purpose: queues command words and sends each one as a mode-0, MSB-first
// SPI frame framed by its own chip-select low period.
// Ports:
//   CLK160M  160 MHz clock, all logic on the rising edge
//   RESET    asynchronous active-high reset; aborts any frame, flushes the queue
//   bus      ptmch_spi_tx_if.master: push handshake, busy/done status, SPI pins
// All outputs come straight from flops.
module ptmch_spi_tx
  import ptmch_pkg::*;
#(
  parameter int DATA_W     = PTMCH_DATA_W,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic           CLK160M,
  input  logic           RESET,
  ptmch_spi_tx_if.master bus
);
  localparam int TMR_W = $clog2(max_of4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE));
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [TMR_W-1:0] DIV_LD   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_IDLE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  spi_tx_state_t     state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              spi_cs_q, spi_cs_d;
  logic              spi_clk_q, spi_clk_d;
  logic              spi_mosi_q, spi_mosi_d;
  logic              done_pls_q, done_pls_d;
  logic              busy_q, busy_d;
  logic              tx_ready_q, tx_ready_d;

  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_d;
  logic              push, pop, pop_next;
  logic              tmr_zero, last_fall;

  assign tmr_zero  = (timer_q == '0);
  // bit_cnt counts falls still to come; the final one ends the shift phase.
  assign last_fall = spi_clk_q && (bit_cnt_q == BIT_W'(1));
  assign push      = bus.tx_valid && tx_ready_q && (!fifo_full || pop);

  ptmch_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK160M),
    .rst       (RESET),
    .push      (push),
    .push_data (bus.tx_data),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SETUP;
      SETUP:   if (tmr_zero) state_d = SHIFT;
      SHIFT:   if (tmr_zero && last_fall) state_d = HOLD;
      HOLD:    if (tmr_zero) state_d = GAP;
      GAP:     if (tmr_zero) state_d = fifo_empty ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    timer_d    = tmr_zero ? '0 : timer_q - 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    spi_cs_d   = spi_cs_q;
    spi_clk_d  = spi_clk_q;
    spi_mosi_d = spi_mosi_q;
    done_pls_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (!fifo_empty && (state_q == IDLE || tmr_zero)) begin
          // First data bit goes out with CS so it has the whole setup time.
          pop        = 1'b1;
          shreg_d    = fifo_rd_data;
          spi_cs_d   = 1'b0;
          spi_mosi_d = fifo_rd_data[DATA_W-1];
          timer_d    = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          timer_d   = DIV_LD;
          bit_cnt_d = BIT_W'(DATA_W);
        end
      end
      SHIFT: begin
        if (tmr_zero) begin
          spi_clk_d = !spi_clk_q;
          timer_d   = DIV_LD;
          if (spi_clk_q) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (last_fall) begin
              timer_d = HOLD_LD;
            end else begin
              shreg_d    = shreg_q << 1;
              spi_mosi_d = shreg_q[DATA_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          spi_cs_d   = 1'b1;
          done_pls_d = 1'b1;
          spi_mosi_d = 1'b0;
          timer_d    = GAP_LD;
        end
      end
      default: ;
    endcase
  end

  // Status flops look one edge ahead so they are exact on the cycle they show.
  // TX_READY also opens while full when the head is popped on the next edge.
  always_comb begin
    count_d    = fifo_count + CNT_W'(push) - CNT_W'(pop);
    busy_d     = (state_d != IDLE) || (count_d != '0);
    pop_next   = (count_d != '0) &&
                 ((state_d == IDLE) || (state_d == GAP && timer_d == '0));
    tx_ready_d = (count_d != FULL_CNT) || pop_next;
  end

  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) begin
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      spi_cs_q   <= 1'b1;
      spi_clk_q  <= 1'b0;
      spi_mosi_q <= 1'b0;
      done_pls_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      spi_cs_q   <= spi_cs_d;
      spi_clk_q  <= spi_clk_d;
      spi_mosi_q <= spi_mosi_d;
      done_pls_q <= done_pls_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done_pls = done_pls_q;
  assign bus.spi_cs   = spi_cs_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.spi_mosi = spi_mosi_q;
endmodule

// File: tb/tb_ptmch_spi_tx.sv
// tb/tb_ptmch_spi_tx.sv - directed self-checking bench for ptmch_spi_tx
module tb_ptmch_spi_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  ptmch_spi_tx_if #(.DATA_W(16)) bus ();

  ptmch_spi_tx #(
    .DATA_W(16), .CLK_DIV(8), .FIFO_DEPTH(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)
  ) dut (
    .CLK160M (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          bits;
    int          low;
  } frame_t;

  frame_t      frames[$];
  int          gaps[$];
  logic [15:0] rx_word = '0;
  int          rx_bits = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          done_cnt = 0;
  int          done_misaligned = 0;
  int          mosi_glitch = 0;
  logic        prev_cs = 1'b1;
  logic        prev_clk = 1'b0;
  logic        prev_mosi = 1'b0;

  // Pin monitor: an SPI slave sampling on each negedge of CLK160M.
  always @(negedge clk) begin
    if (bus.spi_cs === 1'b0) begin
      if (prev_cs === 1'b1) begin
        gaps.push_back(high_cnt);
        low_cnt = 0;
        rx_word = '0;
        rx_bits = 0;
      end
      low_cnt++;
    end else begin
      if (prev_cs === 1'b0) begin
        frames.push_back('{word: rx_word, bits: rx_bits, low: low_cnt});
        high_cnt = 0;
      end
      high_cnt++;
    end
    if (bus.spi_clk === 1'b1 && prev_clk === 1'b0) begin
      rx_word = {rx_word[14:0], bus.spi_mosi};
      rx_bits++;
      if (bus.spi_mosi !== prev_mosi) mosi_glitch++;
    end
    if (bus.done_pls === 1'b1) begin
      done_cnt++;
      if (!(bus.spi_cs === 1'b1 && prev_cs === 1'b0)) done_misaligned++;
    end
    prev_cs   = bus.spi_cs;
    prev_clk  = bus.spi_clk;
    prev_mosi = bus.spi_mosi;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, output bit acc);
    acc = bus.tx_ready;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (frames.size() < target && n < budget) begin
      tick();
      n++;
    end
    ok = (frames.size() >= target);
  endtask

  task automatic test_reset();
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    #1 rst = 1'b1;
    repeat (5) tick();
    checks++; if (bus.spi_cs !== 1'b1)   begin errors++; $display("FAIL reset_cs got %b want 1", bus.spi_cs); end
    checks++; if (bus.spi_clk !== 1'b0)  begin errors++; $display("FAIL reset_clk got %b want 0", bus.spi_clk); end
    checks++; if (bus.spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bus.spi_mosi); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done_pls !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_pls); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.tx_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release got %b want 0", bus.tx_ready); end
    tick();
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_single_frame();
    int fb, d0, m0, g0, n;
    bit acc, ok;
    fb = frames.size(); d0 = done_cnt; m0 = done_misaligned; g0 = mosi_glitch;
    push_word(16'hA55A, acc);
    checks++; if (acc !== 1'b1)      begin errors++; $display("FAIL single_accept got %b want 1", acc); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
    wait_frames(fb + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d frames want %0d", frames.size(), fb + 1); end
    if (ok) begin
      checks++; if (frames[fb].word !== 16'hA55A) begin errors++; $display("FAIL single_word got %h want a55a", frames[fb].word); end
      checks++; if (frames[fb].bits != 16)  begin errors++; $display("FAIL single_rises got %0d want 16", frames[fb].bits); end
      checks++; if (frames[fb].low != 260)  begin errors++; $display("FAIL single_cs_low got %0d want 260", frames[fb].low); end
      checks++; if (bus.spi_mosi !== 1'b0)  begin errors++; $display("FAIL single_mosi_end got %b want 0", bus.spi_mosi); end
      checks++; if (bus.spi_clk !== 1'b0)   begin errors++; $display("FAIL single_clk_end got %b want 0", bus.spi_clk); end
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL single_busy_fall got %0d cycles want 2", n); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt - d0); end
    checks++; if (done_misaligned != m0) begin errors++; $display("FAIL single_done_align got %0d want %0d", done_misaligned, m0); end
    checks++; if (mosi_glitch != g0) begin errors++; $display("FAIL single_mosi_stable got %0d want %0d", mosi_glitch, g0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [5];
    bit          acc [5];
    int          fb, d0;
    bit          a0, ok;
    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h0F0F;
    words[3] = 16'h8001; words[4] = 16'h7E7E;
    fb = frames.size(); d0 = done_cnt;
    push_word(16'hC3A5, a0);
    repeat (10) tick();
    for (int i = 0; i < 5; i++) push_word(words[i], acc[i]);
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got %b want 1", a0); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (acc[i] !== (i < 4)) begin errors++; $display("FAIL b2b_accept%0d got %b want %b", i, acc[i], i < 4); end
    end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", bus.tx_ready); end
    wait_frames(fb + 5, 1600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d frames want %0d", frames.size(), fb + 5); end
    if (ok) begin
      checks++; if (frames[fb].word !== 16'hC3A5) begin errors++; $display("FAIL b2b_word_first got %h want c3a5", frames[fb].word); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (frames[fb+1+i].word !== words[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, frames[fb+1+i].word, words[i]); end
        checks++;
        if (frames[fb+1+i].low != 260) begin errors++; $display("FAIL b2b_low%0d got %0d want 260", i, frames[fb+1+i].low); end
        checks++;
        if (gaps[fb+1+i] != 2) begin errors++; $display("FAIL b2b_gap%0d got %0d want 2", i, gaps[fb+1+i]); end
      end
    end
    repeat (4) tick();
    checks++; if (frames.size() != fb + 5) begin errors++; $display("FAIL b2b_dropped got %0d frames want %0d", frames.size(), fb + 5); end
    checks++; if (done_cnt - d0 != 5) begin errors++; $display("FAIL b2b_done got %0d want 5", done_cnt - d0); end
  endtask

  task automatic test_push_on_pop();
    logic [15:0] ys [5];
    int          fb, n;
    bit          acc, ok;
    ys[0] = 16'h0001; ys[1] = 16'h8000; ys[2] = 16'hFFFF; ys[3] = 16'h0000; ys[4] = 16'h6969;
    fb = frames.size();
    push_word(16'h5A00, acc);
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      push_word(ys[i], acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL pop_fill%0d got %b want 1", i, acc); end
    end
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL pop_ready_open got %b want 1", bus.tx_ready); end
    push_word(ys[4], acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL pop_push_accept got %b want 1", acc); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL pop_still_full got %b want 0", bus.tx_ready); end
    wait_frames(fb + 6, 1900, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pop_timeout got %0d frames want %0d", frames.size(), fb + 6); end
    if (ok) begin
      checks++; if (frames[fb].word !== 16'h5A00) begin errors++; $display("FAIL pop_word_first got %h want 5a00", frames[fb].word); end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (frames[fb+1+i].word !== ys[i]) begin errors++; $display("FAIL pop_word%0d got %h want %h", i, frames[fb+1+i].word, ys[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fb, d0, n;
    bit acc, ok;
    fb = frames.size(); d0 = done_cnt;
    push_word(16'hF00D, acc);
    push_word(16'h1111, acc);
    n = 0;
    while (!(rx_bits == 7 && bus.spi_cs === 1'b0) && n < 400) begin
      tick();
      n++;
    end
    checks++; if (rx_bits != 7) begin errors++; $display("FAIL mid_rise7 got %0d rises want 7", rx_bits); end
    rst = 1'b1;
    #1;
    checks++; if (bus.spi_cs !== 1'b1)   begin errors++; $display("FAIL mid_cs_async got %b want 1", bus.spi_cs); end
    checks++; if (bus.spi_clk !== 1'b0)  begin errors++; $display("FAIL mid_clk got %b want 0", bus.spi_clk); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", bus.tx_ready); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done got %0d want %0d", done_cnt, d0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_fifo_flushed got busy %b want 0", bus.busy); end
    checks++; if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL mid_cs_idle got %b want 1", bus.spi_cs); end
    checks++; if (frames.size() != fb + 1) begin errors++; $display("FAIL mid_frames got %0d want %0d", frames.size(), fb + 1); end
    fb = frames.size(); d0 = done_cnt;
    push_word(16'h3C96, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL mid_new_accept got %b want 1", acc); end
    wait_frames(fb + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_new_timeout got %0d frames want %0d", frames.size(), fb + 1); end
    if (ok) begin
      checks++; if (frames[fb].word !== 16'h3C96) begin errors++; $display("FAIL mid_new_word got %h want 3c96", frames[fb].word); end
      checks++; if (frames[fb].bits != 16) begin errors++; $display("FAIL mid_new_rises got %0d want 16", frames[fb].bits); end
      checks++; if (frames[fb].low != 260) begin errors++; $display("FAIL mid_new_low got %0d want 260", frames[fb].low); end
    end
    tick();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL mid_new_done got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_push_on_pop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
